// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// cpu_pkg : shared datapath widths and load-op codes for the in-order pipeline.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;
  localparam int DW     = 32;
  localparam int LDOP_W = 3;

  typedef enum logic [LDOP_W-1:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_H  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4
  } ld_op_e;

  // Unknown codes behave as a full-word load.
  function automatic logic is_word_op(input logic [LDOP_W-1:0] op);
    return !(op == LD_B || op == LD_H || op == LD_BU || op == LD_HU);
  endfunction
endpackage

`default_nettype wire

// File: rtl/mem_stage_load_extend.sv
//------------------------------------------------------------------------------
// load_extend : combinational byte/half lane select with sign/zero extension.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0]       raw_i,
  input  logic [1:0]        addr_i,
  input  logic [LDOP_W-1:0] ld_op_i,
  output logic [31:0]       result_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = raw_i[7:0];
    case (addr_i)
      2'd1:    w_byte = raw_i[15:8];
      2'd2:    w_byte = raw_i[23:16];
      2'd3:    w_byte = raw_i[31:24];
      default: w_byte = raw_i[7:0];
    endcase
    w_half = addr_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  always_comb begin
    result_o = raw_i;
    case (ld_op_i)
      LD_B:    result_o = {{24{w_byte[7]}}, w_byte};
      LD_BU:   result_o = {24'd0, w_byte};
      LD_H:    result_o = {{16{w_half[15]}}, w_half};
      LD_HU:   result_o = {16'd0, w_half};
      default: result_o = raw_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
//------------------------------------------------------------------------------
// mem_stage : MEM pipeline stage; latches EX results, buffers SRAM read data
// under WB back-pressure. Optional MS_ALE_CHECK_EN adds misaligned-load flag.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage #(
  parameter int DW     = 32,
  parameter int LDOP_W = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [DW-1:0]     es_pc,
  input  logic              es_rf_we,
  input  logic [4:0]        es_rf_waddr,
  input  logic [DW-1:0]     es_alu_result,
  input  logic              es_res_from_mem,
  input  logic [LDOP_W-1:0] es_ld_op,
  input  logic [DW-1:0]     data_sram_rdata,
  input  logic              ws_allowin,
  output logic              ms_to_ws_valid,
  output logic [DW-1:0]     ms_pc,
  output logic              ms_rf_we,
  output logic [4:0]        ms_rf_waddr,
  output logic [DW-1:0]     ms_final_result,
`ifdef MS_ALE_CHECK_EN
  output logic              ms_ale,
`endif
  output logic              ms_res_from_mem
);
  import cpu_pkg::*;

  logic              ms_valid_q, first_q, rf_we_q, res_mem_q, buf_vld_q;
  logic [DW-1:0]     pc_q, alu_q, buf_q;
  logic [4:0]        waddr_q;
  logic [LDOP_W-1:0] ld_op_q;
  logic [DW-1:0]     w_raw, w_ext;
  logic              w_ready_go;

  assign w_ready_go     = 1'b1;
  assign ms_allowin     = !ms_valid_q || (ws_allowin && w_ready_go);
  assign ms_to_ws_valid = ms_valid_q && w_ready_go;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q <= 1'b0;
      first_q    <= 1'b0;
      pc_q       <= '0;
      rf_we_q    <= 1'b0;
      waddr_q    <= '0;
      alu_q      <= '0;
      res_mem_q  <= 1'b0;
      ld_op_q    <= '0;
      buf_q      <= '0;
      buf_vld_q  <= 1'b0;
    end else begin
      if (ms_allowin) ms_valid_q <= es_to_ms_valid;
      if (es_to_ms_valid && ms_allowin) begin
        first_q   <= 1'b1;
        pc_q      <= es_pc;
        rf_we_q   <= es_rf_we;
        waddr_q   <= es_rf_waddr;
        alu_q     <= es_alu_result;
        res_mem_q <= es_res_from_mem;
        ld_op_q   <= es_ld_op;
      end else begin
        first_q <= 1'b0;
      end
      // SRAM data is only valid in the first cycle; capture it if WB stalls us.
      if (ms_to_ws_valid && ws_allowin) begin
        buf_vld_q <= 1'b0;
      end else if (ms_valid_q && first_q && res_mem_q && !ws_allowin) begin
        buf_q     <= data_sram_rdata;
        buf_vld_q <= 1'b1;
      end
    end
  end

  assign w_raw = buf_vld_q ? buf_q : data_sram_rdata;

  load_extend u_load_extend (
    .raw_i    (w_raw),
    .addr_i   (alu_q[1:0]),
    .ld_op_i  (ld_op_q),
    .result_o (w_ext)
  );

  assign ms_final_result = res_mem_q ? w_ext : alu_q;
  assign ms_pc           = pc_q;
  assign ms_rf_waddr     = waddr_q;
  assign ms_res_from_mem = res_mem_q;

`ifdef MS_ALE_CHECK_EN
  assign ms_ale = ms_valid_q && res_mem_q &&
                  (((ld_op_q == LD_H || ld_op_q == LD_HU) && alu_q[0]) ||
                   (is_word_op(ld_op_q) && (alu_q[1:0] != 2'b00)));
  assign ms_rf_we = ms_valid_q && rf_we_q && !ms_ale;
`else
  assign ms_rf_we = ms_valid_q && rf_we_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//------------------------------------------------------------------------------
// tb_mem_stage : directed table vectors plus stall/turnover/reset sequences.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic [31:0] es_alu_result;
  logic        es_res_from_mem;
  logic [2:0]  es_ld_op;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_final_result;
  logic        ms_res_from_mem;
`ifdef MS_ALE_CHECK_EN
  logic        ms_ale;
`endif

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .es_to_ms_valid  (es_to_ms_valid),
    .ms_allowin      (ms_allowin),
    .es_pc           (es_pc),
    .es_rf_we        (es_rf_we),
    .es_rf_waddr     (es_rf_waddr),
    .es_alu_result   (es_alu_result),
    .es_res_from_mem (es_res_from_mem),
    .es_ld_op        (es_ld_op),
    .data_sram_rdata (data_sram_rdata),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_pc           (ms_pc),
    .ms_rf_we        (ms_rf_we),
    .ms_rf_waddr     (ms_rf_waddr),
    .ms_final_result (ms_final_result),
`ifdef MS_ALE_CHECK_EN
    .ms_ale          (ms_ale),
`endif
    .ms_res_from_mem (ms_res_from_mem)
  );

  int errors = 0;
  int checks = 0;
  int xfers  = 0;

  always @(posedge clk)
    if (resetn && ms_to_ws_valid && ws_allowin) xfers <= xfers + 1;

  typedef struct {
    logic        ld;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        we;
    logic [4:0]  waddr;
    logic        mis;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic [2:0] op, input logic [31:0] addr,
                       input logic we, input logic [4:0] waddr, input logic [31:0] pc);
    es_to_ms_valid  = 1'b1;
    es_res_from_mem = ld;
    es_ld_op        = op;
    es_alu_result   = addr;
    es_rf_we        = we;
    es_rf_waddr     = waddr;
    es_pc           = pc;
  endtask

  initial begin
    int base;
    resetn = 1'b0; es_to_ms_valid = 1'b0; es_pc = '0; es_rf_we = 1'b0;
    es_rf_waddr = '0; es_alu_result = '0; es_res_from_mem = 1'b0; es_ld_op = '0;
    data_sram_rdata = 32'h5A5A_5A5A; ws_allowin = 1'b1;

    //              ld  op    addr          rdata         we waddr mis exp
    vecs[0]  = '{1'b0, 3'd0, 32'h1234_5678, 32'h0,        1'b1, 5'd5,  1'b0, 32'h1234_5678};
    vecs[1]  = '{1'b1, 3'd1, 32'h0000_1003, 32'h80FF_0011, 1'b1, 5'd6,  1'b0, 32'hFFFF_FF80};
    vecs[2]  = '{1'b1, 3'd3, 32'h0000_1003, 32'h80FF_0011, 1'b1, 5'd7,  1'b0, 32'h0000_0080};
    vecs[3]  = '{1'b1, 3'd2, 32'h0000_1002, 32'h8001_7FFE, 1'b1, 5'd8,  1'b0, 32'hFFFF_8001};
    vecs[4]  = '{1'b1, 3'd4, 32'h0000_1000, 32'h8001_7FFE, 1'b1, 5'd9,  1'b0, 32'h0000_7FFE};
    vecs[5]  = '{1'b1, 3'd1, 32'h0000_1000, 32'h80FF_0011, 1'b1, 5'd10, 1'b0, 32'h0000_0011};
    vecs[6]  = '{1'b1, 3'd1, 32'h0000_1001, 32'h80FF_0011, 1'b1, 5'd11, 1'b0, 32'h0000_0000};
    vecs[7]  = '{1'b1, 3'd1, 32'h0000_1002, 32'h80FF_0011, 1'b1, 5'd12, 1'b0, 32'hFFFF_FFFF};
    vecs[8]  = '{1'b1, 3'd0, 32'h0000_2000, 32'hCAFE_F00D, 1'b1, 5'd13, 1'b0, 32'hCAFE_F00D};
    vecs[9]  = '{1'b1, 3'd5, 32'h0000_2004, 32'h0BAD_C0DE, 1'b1, 5'd14, 1'b0, 32'h0BAD_C0DE};
    vecs[10] = '{1'b1, 3'd4, 32'h0000_1003, 32'h8001_7FFE, 1'b1, 5'd15, 1'b1, 32'h0000_8001};
    vecs[11] = '{1'b1, 3'd0, 32'h0000_3002, 32'h1122_3344, 1'b1, 5'd16, 1'b1, 32'h1122_3344};

    tick(); tick();
    resetn = 1'b1;
    #1;
    chk("reset_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("reset_rf_we", {31'd0, ms_rf_we}, 32'd0);
    chk("reset_result", ms_final_result, 32'd0);
    chk("reset_pc", ms_pc, 32'd0);
    chk("reset_allowin", {31'd0, ms_allowin}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      logic exp_we;
      chk("bubble_rf_we", {31'd0, ms_rf_we}, 32'd0);
      issue(vecs[i].ld, vecs[i].op, vecs[i].addr, vecs[i].we, vecs[i].waddr, 32'h1C00_0000 + i * 4);
      ws_allowin = 1'b1;
      tick();
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = vecs[i].rdata;
      #1;
      exp_we = vecs[i].we;
`ifdef MS_ALE_CHECK_EN
      exp_we = vecs[i].we & ~vecs[i].mis;
      chk($sformatf("v%0d_ale", i), {31'd0, ms_ale}, {31'd0, vecs[i].mis});
`endif
      chk($sformatf("v%0d_valid", i), {31'd0, ms_to_ws_valid}, 32'd1);
      chk($sformatf("v%0d_result", i), ms_final_result, vecs[i].exp);
      chk($sformatf("v%0d_rf_we", i), {31'd0, ms_rf_we}, {31'd0, exp_we});
      chk($sformatf("v%0d_waddr", i), {27'd0, ms_rf_waddr}, {27'd0, vecs[i].waddr});
      chk($sformatf("v%0d_pc", i), ms_pc, 32'h1C00_0000 + i * 4);
      chk($sformatf("v%0d_ldflag", i), {31'd0, ms_res_from_mem}, {31'd0, vecs[i].ld});
      tick();
    end

    // Back-pressure: buffered data must survive SRAM output change.
    base = xfers;
    issue(1'b1, 3'd0, 32'h0000_4000, 1'b1, 5'd20, 32'h1C00_1000);
    tick();
    es_to_ms_valid = 1'b0; data_sram_rdata = 32'hDEAD_BEEF; ws_allowin = 1'b0;
    #1;
    chk("stall_c1_result", ms_final_result, 32'hDEAD_BEEF);
    chk("stall_c1_allowin", {31'd0, ms_allowin}, 32'd0);
    tick();
    data_sram_rdata = 32'h0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("stall_hold_result", ms_final_result, 32'hDEAD_BEEF);
      chk("stall_hold_allowin", {31'd0, ms_allowin}, 32'd0);
      chk("stall_hold_valid", {31'd0, ms_to_ws_valid}, 32'd1);
      tick();
    end
    ws_allowin = 1'b1;
    #1;
    chk("release_result", ms_final_result, 32'hDEAD_BEEF);
    chk("release_allowin", {31'd0, ms_allowin}, 32'd1);
    tick(); tick();
    chk("release_xfers", xfers - base, 32'd1);
    chk("release_valid", {31'd0, ms_to_ws_valid}, 32'd0);

    // Turnover: second load enters as buffered first load leaves.
    issue(1'b1, 3'd0, 32'h0000_5000, 1'b1, 5'd21, 32'h1C00_2000);
    tick();
    es_to_ms_valid = 1'b0; data_sram_rdata = 32'h1111_1111; ws_allowin = 1'b0;
    tick();
    data_sram_rdata = 32'h0; ws_allowin = 1'b1;
    issue(1'b1, 3'd0, 32'h0000_5004, 1'b1, 5'd22, 32'h1C00_2004);
    #1;
    chk("turn_a_result", ms_final_result, 32'h1111_1111);
    tick();
    es_to_ms_valid = 1'b0; data_sram_rdata = 32'h2222_2222; ws_allowin = 1'b0;
    #1;
    chk("turn_b_result", ms_final_result, 32'h2222_2222);
    chk("turn_b_waddr", {27'd0, ms_rf_waddr}, 32'd22);
    tick();
    data_sram_rdata = 32'h3333_3333;
    #1;
    chk("turn_b_hold", ms_final_result, 32'h2222_2222);
    ws_allowin = 1'b1;
    tick();

    // Reset in the middle of a stall.
    issue(1'b1, 3'd0, 32'h0000_6000, 1'b1, 5'd23, 32'h1C00_3000);
    tick();
    es_to_ms_valid = 1'b0; data_sram_rdata = 32'hABCD_1234; ws_allowin = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1; ws_allowin = 1'b1;
    base = xfers;
    #1;
    chk("rst_stall_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("rst_stall_rf_we", {31'd0, ms_rf_we}, 32'd0);
    tick(); tick();
    chk("rst_stall_xfers", xfers - base, 32'd0);
    issue(1'b1, 3'd0, 32'h0000_7000, 1'b1, 5'd24, 32'h1C00_4000);
    tick();
    es_to_ms_valid = 1'b0; data_sram_rdata = 32'h7777_0000;
    #1;
    chk("rst_fresh_result", ms_final_result, 32'h7777_0000);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
